// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and colour helpers for the timing generator and renderers.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam int PIPE_LAT = 2;

  typedef logic [7:0] colour_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
  function automatic rgb_t expand_colour(input colour_t c);
    rgb_t o;
    o.r = {c[7:5], c[7:5], c[7:6]};
    o.g = {c[4:2], c[4:2], c[4:3]};
    o.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
    return o;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that re-aligns raster control bits with the renderer pipeline.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = PIPE_LAT,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync decode, per-frame tick and blanked colour expansion toward the VGA DAC.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP,
  parameter int P_PIPE_LAT = PIPE_LAT
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  colour_t    pixel_color,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       frame_tick,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int H_TOT = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
  localparam int V_TOT = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;
  localparam int HS_S  = P_H_ACTIVE + P_H_FP;
  localparam int HS_E  = HS_S + P_H_SYNC;
  localparam int VS_S  = P_V_ACTIVE + P_V_FP;
  localparam int VS_E  = VS_S + P_V_SYNC;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_last, v_last;

  assign h_last = (h_cnt_q == 10'(H_TOT - 1));
  assign v_last = (v_cnt_q == 10'(V_TOT - 1));

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic hs_raw_n, vs_raw_n;

  assign x        = h_cnt_q;
  assign y        = v_cnt_q;
  assign video_on = (h_cnt_q < 10'(P_H_ACTIVE)) && (v_cnt_q < 10'(P_V_ACTIVE));
  assign hs_raw_n = !((h_cnt_q >= 10'(HS_S)) && (h_cnt_q < 10'(HS_E)));
  assign vs_raw_n = !((v_cnt_q >= 10'(VS_S)) && (v_cnt_q < 10'(VS_E)));

  // Bit order {video_on, vs_n, hs_n}; reset value holds syncs idle-high and blanking active.
  logic [2:0] ctl_dly;

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (P_PIPE_LAT),
    .RST_VAL (3'b011)
  ) u_ctl_dly (
    .clk_i   (vga_clk),
    .rst_n_i (rst_n),
    .d_i     ({video_on, vs_raw_n, hs_raw_n}),
    .q_o     (ctl_dly)
  );

  logic hs_q, vs_q, blank_n_q, tick_q;
  rgb_t rgb_q, rgb_d;

  always_comb begin
    rgb_d = '0;
    if (ctl_dly[2]) rgb_d = expand_colour(pixel_color);
  end

  // Tick fires on the first clock of vertical blanking.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      hs_q      <= ctl_dly[0];
      vs_q      <= ctl_dly[1];
      blank_n_q <= ctl_dly[2];
      rgb_q     <= rgb_d;
      tick_q    <= h_last && (v_cnt_q == 10'(P_V_ACTIVE - 1));
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size raster for line timing and colour, a shrunken raster for frame-level timing.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_n, rst_s_n;
  logic [7:0] pix;

  logic [9:0] x, y, xs, ys;
  logic       von, tick, hs, vs, bln, syn;
  logic       von_s, tick_s, hs_s, vs_s, bln_s, syn_s;
  logic [7:0] r, g, b, rs, gs, bs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen dut (
    .vga_clk(clk), .rst_n(rst_n), .pixel_color(pix),
    .x(x), .y(y), .video_on(von), .frame_tick(tick),
    .vga_hs(hs), .vga_vs(vs), .vga_blank_n(bln), .vga_sync_n(syn),
    .vga_r(r), .vga_g(g), .vga_b(b)
  );

  // 25 x 13 raster: frame = 325 clocks, vsync lines 8..9, vblank starts at line 6.
  vga_timing_gen #(
    .P_H_ACTIVE(16), .P_H_FP(2), .P_H_SYNC(4), .P_H_BP(3),
    .P_V_ACTIVE(6),  .P_V_FP(2), .P_V_SYNC(2), .P_V_BP(3),
    .P_PIPE_LAT(2)
  ) dut_s (
    .vga_clk(clk), .rst_n(rst_s_n), .pixel_color(pix),
    .x(xs), .y(ys), .video_on(von_s), .frame_tick(tick_s),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bln_s), .vga_sync_n(syn_s),
    .vga_r(rs), .vga_g(gs), .vga_b(bs)
  );

  typedef struct {
    logic [7:0] pix;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  int hs_prev, hs_fall1, hs_fall2, hs_low, blank_cnt, blank_err, vis_err;
  int vs_fall_s, vs_low_s, vs_prev_s, tick_first_s, tick_cnt_s, blank_err_s;
  int found;

  initial begin
    vecs[0] = '{8'b111_000_00, 8'hFF, 8'h00, 8'h00};
    vecs[1] = '{8'b000_000_10, 8'h00, 8'h00, 8'hAA};
    vecs[2] = '{8'b000_111_00, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'b000_000_11, 8'h00, 8'h00, 8'hFF};
    vecs[4] = '{8'b101_010_01, 8'hB6, 8'h49, 8'h55};
    vecs[5] = '{8'b011_100_10, 8'h6D, 8'h92, 8'hAA};
    vecs[6] = '{8'b001_001_01, 8'h24, 8'h24, 8'h55};
    vecs[7] = '{8'hFF,         8'hFF, 8'hFF, 8'hFF};

    rst_n = 1'b0; rst_s_n = 1'b0; pix = 8'hFF;
    step(10);
    chk("rst_hs", hs, 1); chk("rst_vs", vs, 1); chk("rst_blank_n", bln, 0);
    chk("rst_rgb", {r, g, b}, 0); chk("rst_x", x, 0); chk("rst_y", y, 0);
    chk("rst_video_on", von, 1); chk("rst_tick", tick, 0); chk("sync_n", syn, 0);

    rst_n = 1'b1; rst_s_n = 1'b1; cyc = 0;
    step(1);
    chk("first_edge_x", x, 1);
    step(4);

    for (int i = 0; i < 8; i++) begin
      pix = vecs[i].pix;
      step(1);
      chk($sformatf("vec%0d_blank_n", i), bln, 1);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_g", i), g, vecs[i].g);
      chk($sformatf("vec%0d_b", i), b, vecs[i].b);
    end

    pix = 8'hFF;
    hs_prev = hs; hs_fall1 = -1; hs_fall2 = -1; hs_low = 0;
    blank_cnt = 0; blank_err = 0; vis_err = 0;
    vs_prev_s = vs_s; vs_fall_s = -1; vs_low_s = 0;
    tick_first_s = -1; tick_cnt_s = 0; blank_err_s = 0;
    while (cyc < 1700) begin
      step(1);
      if (hs_prev == 1 && hs == 0) begin
        if (hs_fall1 < 0) hs_fall1 = cyc;
        else if (hs_fall2 < 0) hs_fall2 = cyc;
      end
      hs_prev = hs;
      if (cyc < 800 && hs == 0) hs_low++;
      if (cyc >= 803 && cyc <= 1602 && bln) blank_cnt++;
      if (!bln && {r, g, b} != 24'h0) blank_err++;
      if (bln && {r, g, b} != 24'hFFFFFF) vis_err++;
      if (!bln_s && {rs, gs, bs} != 24'h0) blank_err_s++;
      if (vs_prev_s == 1 && vs_s == 0 && vs_fall_s < 0) vs_fall_s = cyc;
      vs_prev_s = vs_s;
      if (cyc < 325 && vs_s == 0) vs_low_s++;
      if (tick_s) begin
        if (tick_first_s < 0) tick_first_s = cyc;
        tick_cnt_s++;
      end
      if (cyc == 639) chk("video_on_x639", von, 1);
      if (cyc == 640) chk("video_on_x640", von, 0);
      if (cyc == 642) chk("blank_n_last_vis", bln, 1);
      if (cyc == 643) chk("blank_n_first_blank", bln, 0);
      if (cyc == 799) chk("x_799", x, 799);
      if (cyc == 800) chk("x_wrap_y", {x, y}, {10'd0, 10'd1});
      if (cyc == 1000) chk("tick_idle", tick, 0);
    end
    chk("hs_fall_first", hs_fall1, 659);
    chk("hs_low_width", hs_low, 96);
    chk("hs_line_period", hs_fall2 - hs_fall1, 800);
    chk("blank_n_per_line", blank_cnt, 640);
    chk("rgb_zero_in_blank", blank_err, 0);
    chk("rgb_full_in_visible", vis_err, 0);
    chk("s_rgb_zero_in_blank", blank_err_s, 0);
    chk("s_vs_fall", vs_fall_s, 203);
    chk("s_vs_low_width", vs_low_s, 50);
    chk("s_tick_first", tick_first_s, 150);
    chk("s_tick_count", tick_cnt_s, 5);

    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      step(1);
      if (xs == 10 && ys == 3) found = 1;
    end
    chk("s_reach_midframe", found, 1);
    chk("s_mid_blank_n", bln_s, 1);
    chk("s_mid_r", rs, 8'hFF);
    rst_n = 1'b0; rst_s_n = 1'b0;
    #2;
    chk("async_s_xy", {xs, ys}, 0);
    chk("async_s_sync", {hs_s, vs_s}, 2'b11);
    chk("async_s_blank_n", bln_s, 0);
    chk("async_s_rgb", {rs, gs, bs}, 0);
    chk("async_xy", {x, y}, 0);
    chk("async_rgb", {r, g, b}, 0);
    step(3);
    rst_n = 1'b1; rst_s_n = 1'b1; cyc = 0;
    hs_prev = hs; hs_fall1 = -1; tick_first_s = -1;
    while (cyc < 700) begin
      step(1);
      if (hs_prev == 1 && hs == 0 && hs_fall1 < 0) hs_fall1 = cyc;
      hs_prev = hs;
      if (tick_s && tick_first_s < 0) tick_first_s = cyc;
    end
    chk("post_rst_hs_fall", hs_fall1, 659);
    chk("post_rst_s_tick_first", tick_first_s, 150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
